// File: rtl/sqta_ucode_sequencer.sv
// Microprogram sequencer with an 8-word writable control store (TEST / false-next / true-next / Z).
// Optional watchdog abort is enabled by defining SQTA_WATCHDOG_EN.
module sqta_ucode_sequencer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [10:0]      cfg_data,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic             halt_req,
  input  logic             step,
  input  logic [2:0]       X,
  output logic [2:0]       Z,
  output logic [AW-1:0]    upc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  function automatic logic [10:0] default_word(input int idx);
    case (idx)
      0:       return 11'b01001010000;
      1:       return 11'b11110101100;
      2:       return 11'b10011101000;
      3:       return 11'b00100100010;
      4:       return 11'b01000100100;
      5:       return 11'b00000000001;
      6:       return 11'b10101000010;
      default: return 11'b00000000000;
    endcase
  endfunction

  state_t state, state_base, state_nxt;

  logic [10:0]   store [DEPTH];
  logic [10:0]   word;
  logic [1:0]    test;
  logic          sel;
  logic [AW-1:0] false_next;
  logic [AW-1:0] true_next;
  logic [AW-1:0] next_upc;
  logic          terminal;
  logic          exec;
  logic          load_start;
  logic          wdog_trip;
  logic          cfg_wr;

  assign word       = store[upc];
  assign test       = word[10:9];
  assign false_next = word[8:6];
  assign true_next  = word[5:3];
  assign terminal   = (test == 2'b00) && (false_next == upc);
  assign next_upc   = sel ? true_next : false_next;

  assign busy      = (state != IDLE);
  assign cfg_ready = (state != RUN);
  assign cfg_wr    = cfg_valid && cfg_ready;

  always_comb begin
    sel = 1'b0;
    case (test)
      2'd1:    sel = X[0];
      2'd2:    sel = X[1];
      2'd3:    sel = X[2];
      default: sel = 1'b0;
    endcase
  end

  // halt_req beats start in RUN; start beats step in PAUSE
  always_comb begin
    exec       = 1'b0;
    load_start = 1'b0;
    state_base = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_base = RUN;
          load_start = 1'b1;
        end
      end
      RUN: begin
        if (halt_req) state_base = PAUSE;
        else          exec       = 1'b1;
      end
      PAUSE: begin
        if (start)     state_base = RUN;
        else if (step) exec       = 1'b1;
      end
      default: state_base = IDLE;
    endcase
  end

  always_comb begin
    state_nxt = state_base;
    if (exec && (terminal || wdog_trip)) state_nxt = IDLE;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= default_word(i);
    end else if (cfg_wr) begin
      store[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      upc       <= '0;
      Z         <= '0;
      done      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      done <= exec && terminal;
      if (load_start) begin
        upc       <= start_addr;
        cycle_cnt <= '0;
      end else if (exec) begin
        upc <= next_upc;
        Z   <= wdog_trip ? 3'b000 : word[2:0];
        if (cycle_cnt != {CNT_W{1'b1}}) cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

`ifdef SQTA_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  logic [WW-1:0] wdog_cnt;

  // trips on the microcycle that would make the count reach the limit
  assign wdog_trip = exec && !terminal && (wdog_cnt == WW'(WDOG_LIMIT - 1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wdog_cnt <= '0;
      err      <= 1'b0;
    end else if (load_start) begin
      wdog_cnt <= '0;
      err      <= 1'b0;
    end else if (exec) begin
      if (wdog_cnt != WW'(WDOG_LIMIT)) wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_trip) err <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
